// File: rtl/camera_config_pkg.sv
// camera_pkg: shared FSM states, ROM entry format and SCCB frame helpers.
// DELAY only exists when CAMERA_CONFIG_DELAY_EN is defined.
package camera_pkg;
    localparam int          ENTRY_W    = 16;
    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [7:0]  DELAY_ADDR = 8'hF0;

    typedef enum logic [2:0] {
        IDLE, FETCH, START, BIT, STOP, GAP,
`ifdef CAMERA_CONFIG_DELAY_EN
        DELAY,
`endif
        DONE
    } state_t;

    // Three bytes, each trailed by a released don't-care bit (sent as 1).
    function automatic logic [26:0] sccb_frame(input logic [7:0] id,
                                               input logic [7:0] addr,
                                               input logic [7:0] val);
        return {id, 1'b1, addr, 1'b1, val, 1'b1};
    endfunction

    function automatic logic ack_slot(input logic [4:0] s);
        return (s == 5'd8) || (s == 5'd17) || (s == 5'd26);
    endfunction
endpackage

// File: rtl/camera_config_if.sv
// camera_config_if: control and SCCB pins of the camera loader.
interface camera_config_if;
    logic       start;
    logic       sioc;
    logic       siod_out;
    logic       siod_oe;
    logic       busy;
    logic       done;
    logic [7:0] index;

    modport master (input start,
                    output sioc, siod_out, siod_oe, busy, done, index);
    modport slave  (output start,
                    input sioc, siod_out, siod_oe, busy, done, index);
endinterface

// File: rtl/camera_config_rom.sv
// camera_config_rom: register tables, 1-cycle registered read.
module camera_config_rom
    import camera_pkg::*;
#(
    parameter int PROFILE = 0
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic [7:0]         i_addr,
    output logic [ENTRY_W-1:0] o_data
);
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] r_data;

    always_comb begin
        w_entry = END_MARK;
        case (PROFILE)
            1: if (i_addr == 8'd0) w_entry = 16'h1280;
            2: w_entry = END_MARK;
            3: case (i_addr)
                   8'd0:    w_entry = {DELAY_ADDR, 8'h00};
                   8'd1:    w_entry = 16'h1101;
                   default: w_entry = END_MARK;
               endcase
            // QVGA RGB565 bring-up; the F0 entry waits out the soft reset
            default: case (i_addr)
                   8'd0:    w_entry = 16'h1280;
                   8'd1:    w_entry = {DELAY_ADDR, 8'h00};
                   8'd2:    w_entry = 16'h1214;
                   8'd3:    w_entry = 16'h1100;
                   8'd4:    w_entry = 16'h0C04;
                   8'd5:    w_entry = 16'h3E19;
                   8'd6:    w_entry = 16'h4010;
                   8'd7:    w_entry = 16'h8C00;
                   8'd8:    w_entry = 16'h0400;
                   8'd9:    w_entry = 16'h3A04;
                   8'd10:   w_entry = 16'h3DC0;
                   8'd11:   w_entry = 16'h1418;
                   8'd12:   w_entry = 16'h4F80;
                   8'd13:   w_entry = 16'h5080;
                   8'd14:   w_entry = 16'h5100;
                   8'd15:   w_entry = 16'h5222;
                   8'd16:   w_entry = 16'h535E;
                   8'd17:   w_entry = 16'h5480;
                   8'd18:   w_entry = 16'h589E;
                   default: w_entry = END_MARK;
               endcase
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) r_data <= END_MARK;
        else     r_data <= w_entry;
    end

    assign o_data = r_data;
endmodule

// File: rtl/camera_config.sv
// camera_config: walks the ROM table and writes each entry over SCCB.
// Define CAMERA_CONFIG_DELAY_EN to turn 8'hF0 entries into timed pauses.
module camera_config
    import camera_pkg::*;
#(
    parameter int         QUARTER      = 250,
    parameter logic [7:0] DEV_ID       = 8'h42,
    parameter int         DELAY_CYCLES = 1_000_000,
    parameter int         PROFILE      = 0
) (
    input  logic            clk_in,
    input  logic            rst,
    camera_config_if.master bus
);
    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QUARTER - 1);

    state_t             r_state;
    logic [QW-1:0]      r_q;
    logic [1:0]         r_ph;
    logic [4:0]         r_slot;
    logic [26:0]        r_frame;
    logic               r_fetch;
    logic               r_sioc;
    logic               r_sd;
    logic               r_oe;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_index;
    logic [ENTRY_W-1:0] w_entry;
    logic               w_qend;
    logic [4:0]         w_nslot;
`ifdef CAMERA_CONFIG_DELAY_EN
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    logic [DW-1:0]      r_dly;
`endif

    camera_config_rom #(.PROFILE(PROFILE)) u_rom (
        .clk_in (clk_in),
        .rst    (rst),
        .i_addr (r_index),
        .o_data (w_entry)
    );

    assign w_qend  = (r_q == '0);
    assign w_nslot = r_slot + 5'd1;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_ph    <= '0;
            r_slot  <= '0;
            r_frame <= '0;
            r_fetch <= 1'b0;
            r_sioc  <= 1'b1;
            r_sd    <= 1'b1;
            r_oe    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_index <= '0;
`ifdef CAMERA_CONFIG_DELAY_EN
            r_dly   <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE, DONE: if (bus.start) begin
                    r_state <= FETCH;
                    r_fetch <= 1'b0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_index <= '0;
                end
                // first cycle addresses the ROM, second decodes its word
                FETCH: if (!r_fetch) begin
                    r_fetch <= 1'b1;
                end else begin
                    r_fetch <= 1'b0;
                    if (w_entry == END_MARK) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
`ifdef CAMERA_CONFIG_DELAY_EN
                    else if (w_entry[15:8] == DELAY_ADDR) begin
                        r_state <= DELAY;
                        r_dly   <= DW'(DELAY_CYCLES - 1);
                    end
`endif
                    else begin
                        r_state <= START;
                        r_frame <= sccb_frame(DEV_ID, w_entry[15:8],
                                              w_entry[7:0]);
                        r_ph    <= '0;
                        r_q     <= QMAX;
                        r_sioc  <= 1'b1;
                        r_sd    <= 1'b0;
                        r_oe    <= 1'b1;
                    end
                end
                START: if (w_qend) begin
                    r_q <= QMAX;
                    if (r_ph == 2'd0) begin
                        r_ph   <= 2'd1;
                        r_sioc <= 1'b0;
                    end else begin
                        r_state <= BIT;
                        r_ph    <= '0;
                        r_slot  <= '0;
                        r_sd    <= r_frame[26];
                        r_frame <= {r_frame[25:0], 1'b0};
                        r_oe    <= 1'b1;
                    end
                end else begin
                    r_q <= r_q - 1'b1;
                end
                BIT: if (w_qend) begin
                    r_q  <= QMAX;
                    r_ph <= r_ph + 2'd1;
                    unique case (r_ph)
                        2'd0: r_sioc <= 1'b1;
                        2'd1: ;
                        2'd2: r_sioc <= 1'b0;
                        2'd3: if (r_slot == 5'd26) begin
                            r_state <= STOP;
                            r_sd    <= 1'b0;
                            r_oe    <= 1'b1;
                        end else begin
                            r_slot  <= w_nslot;
                            r_sd    <= r_frame[26];
                            r_frame <= {r_frame[25:0], 1'b0};
                            r_oe    <= ~ack_slot(w_nslot);
                        end
                    endcase
                end else begin
                    r_q <= r_q - 1'b1;
                end
                STOP: if (w_qend) begin
                    r_q <= QMAX;
                    if (r_ph == 2'd0) begin
                        r_ph   <= 2'd1;
                        r_sioc <= 1'b1;
                    end else begin
                        r_state <= GAP;
                        r_ph    <= '0;
                        r_sd    <= 1'b1;
                    end
                end else begin
                    r_q <= r_q - 1'b1;
                end
                GAP: if (w_qend) begin
                    r_q <= QMAX;
                    if (r_ph == 2'd3) begin
                        r_state <= FETCH;
                        r_ph    <= '0;
                        r_index <= r_index + 8'd1;
                    end else begin
                        r_ph <= r_ph + 2'd1;
                    end
                end else begin
                    r_q <= r_q - 1'b1;
                end
`ifdef CAMERA_CONFIG_DELAY_EN
                DELAY: if (r_dly == '0) begin
                    r_state <= FETCH;
                    r_index <= r_index + 8'd1;
                end else begin
                    r_dly <= r_dly - 1'b1;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sioc     = r_sioc;
    assign bus.siod_out = r_sd;
    assign bus.siod_oe  = r_oe;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.index    = r_index;
endmodule

// File: tb/tb_camera_config.sv
// tb_camera_config: three loaders (two-entry, empty, delay tables)
// checked cycle by cycle against a waveform model built from the tables.
module tb_camera_config;
    import camera_pkg::*;

    localparam int Q = 2;
    localparam int D = 20;
`ifdef CAMERA_CONFIG_DELAY_EN
    localparam bit DLY_EN = 1'b1;
`else
    localparam bit DLY_EN = 1'b0;
`endif

    typedef struct packed {
        logic       sioc;
        logic       sd;
        logic       oe;
        logic       busy;
        logic       done;
        logic [7:0] idx;
    } obs_t;

    typedef struct {
        int dut;
        bit rnd;
        int writes;
        int fidx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_chk = 0;
    int          n_pass = 0;
    obs_t        exp_q[$];
    logic [7:0]  exp_bytes[$];
    logic [15:0] rom_q[$];
    vec_t        tv[6];

    always #5 clk = ~clk;

    camera_config_if b0 ();
    camera_config_if b1 ();
    camera_config_if b2 ();

    camera_config #(.QUARTER(Q), .DEV_ID(8'h42), .DELAY_CYCLES(D),
                    .PROFILE(1)) u0 (.clk_in(clk), .rst(rst), .bus(b0));
    camera_config #(.QUARTER(Q), .DEV_ID(8'h42), .DELAY_CYCLES(D),
                    .PROFILE(2)) u1 (.clk_in(clk), .rst(rst), .bus(b1));
    camera_config #(.QUARTER(Q), .DEV_ID(8'h42), .DELAY_CYCLES(D),
                    .PROFILE(3)) u2 (.clk_in(clk), .rst(rst), .bus(b2));

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic obs_t observe(input int s);
        obs_t o;
        case (s)
            0: o = {b0.sioc, b0.siod_out, b0.siod_oe, b0.busy, b0.done, b0.index};
            1: o = {b1.sioc, b1.siod_out, b1.siod_oe, b1.busy, b1.done, b1.index};
            default:
               o = {b2.sioc, b2.siod_out, b2.siod_oe, b2.busy, b2.done, b2.index};
        endcase
        return o;
    endfunction

    task automatic drive(input int s, input logic v);
        case (s)
            0: b0.start = v;
            1: b1.start = v;
            default: b2.start = v;
        endcase
    endtask

    task automatic load_rom(input int s);
        case (s)
            0: rom_q = '{16'h1280, 16'hFFFF};
            1: rom_q = '{16'hFFFF};
            default: rom_q = '{16'hF000, 16'h1101, 16'hFFFF};
        endcase
    endtask

    task automatic add(input int n, input obs_t v);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    // Expected pin levels for every cycle after the start edge.
    task automatic build_model();
        logic [7:0] ix;
        logic [7:0] by[3];
        logic       bv;
        logic       en;
        exp_q.delete();
        exp_bytes.delete();
        for (int i = 0; i < rom_q.size(); i++) begin
            ix = 8'(i);
            add(2, {3'b111, 2'b10, ix});
            if (rom_q[i] == 16'hFFFF) begin
                add(4, {3'b111, 2'b01, ix});
                break;
            end
            if (DLY_EN && rom_q[i][15:8] == 8'hF0) begin
                add(D, {3'b111, 2'b10, ix});
                continue;
            end
            by[0] = 8'h42;
            by[1] = rom_q[i][15:8];
            by[2] = rom_q[i][7:0];
            add(Q, {3'b101, 2'b10, ix});
            add(Q, {3'b001, 2'b10, ix});
            for (int b = 0; b < 3; b++) begin
                exp_bytes.push_back(by[b]);
                for (int k = 0; k < 9; k++) begin
                    en = (k < 8);
                    bv = en ? by[b][7-k] : 1'b1;
                    add(Q, {1'b0, bv, en, 2'b10, ix});
                    add(2 * Q, {1'b1, bv, en, 2'b10, ix});
                    add(Q, {1'b0, bv, en, 2'b10, ix});
                end
            end
            add(Q, {3'b001, 2'b10, ix});
            add(Q, {3'b101, 2'b10, ix});
            add(4 * Q, {3'b111, 2'b10, ix});
        end
    endtask

    task automatic run_seq(input int s, input bit rnd, input int exp_w,
                           output int first_done);
        obs_t       o;
        obs_t       p;
        obs_t       e;
        logic [12:0] m;
        logic       bq[$];
        logic [7:0] got[$];
        logic [7:0] t;
        int         writes, falls, oe_runs, oe_low, hi_chg;
        writes = 0; falls = 0; oe_runs = 0; oe_low = 0; hi_chg = 0;
        first_done = -1;
        p = {3'b111, 2'b00, 8'h00};
        @(negedge clk);
        drive(s, 1'b1);
        @(negedge clk);
        drive(s, 1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            o = observe(s);
            e = exp_q[k];
            m = e.oe ? 13'h1FFF : 13'h17FF;
            check($sformatf("dut%0d_cyc%0d", s, k), 32'(o & m), 32'(e & m));
            if (first_done < 0 && o.done) first_done = k;
            if (p.sioc && !o.sioc) falls++;
            if (p.oe && !o.oe) oe_runs++;
            if (!o.oe) oe_low++;
            if (p.sioc && o.sioc && p.sd != o.sd) hi_chg++;
            if (p.sioc && o.sioc && p.sd && !o.sd) begin
                writes++;
                bq.delete();
            end
            if (!p.sioc && o.sioc) bq.push_back(o.sd);
            if (p.sioc && o.sioc && !p.sd && o.sd && bq.size() >= 26) begin
                for (int b = 0; b < 3; b++) begin
                    t = '0;
                    for (int j = 0; j < 8; j++) t = {t[6:0], bq[9*b+j]};
                    got.push_back(t);
                end
            end
            drive(s, rnd && e.busy && ($urandom_range(0, 7) == 0));
            p = o;
            @(negedge clk);
        end
        drive(s, 1'b0);
        check("writes", writes, exp_w);
        check("sioc_falls", falls, 28 * exp_w);
        check("ack_slots", oe_runs, 3 * exp_w);
        check("ack_cycles", oe_low, 12 * Q * exp_w);
        check("sd_change_sioc_hi", hi_chg, 2 * exp_w);
        check("nbytes", got.size(), exp_bytes.size());
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++)
            check($sformatf("byte%0d", i), got[i], exp_bytes[i]);
    endtask

    initial begin
        obs_t o;
        int   fd;
        int   k0;
        int   mc;
        tv[0] = '{0, 1'b0, 1, 1};
        tv[1] = '{1, 1'b1, 0, 0};
        tv[2] = '{2, 1'b1, DLY_EN ? 1 : 2, 2};
        tv[3] = '{0, 1'b1, 1, 1};
        tv[4] = '{2, 1'b0, DLY_EN ? 1 : 2, 2};
        tv[5] = '{1, 1'b0, 0, 0};
        b0.start = 1'b0;
        b1.start = 1'b0;
        b2.start = 1'b0;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++)
            check($sformatf("reset_dut%0d", s), observe(s), {3'b111, 2'b00, 8'h00});
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int s = 0; s < 3; s++)
            check($sformatf("idle_dut%0d", s), observe(s), {3'b111, 2'b00, 8'h00});

        for (int i = 0; i < 6; i++) begin
            load_rom(tv[i].dut);
            build_model();
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_seq(tv[i].dut, tv[i].rnd, tv[i].writes, fd);
            o = observe(tv[i].dut);
            check("final_done", o.done, 1);
            check("final_busy", o.busy, 0);
            check("final_idx", o.idx, tv[i].fidx);
            if (tv[i].dut == 1)
                check("done_within_4", 32'(fd >= 0 && fd < 4), 1);
        end

        // reset in the sioc-high half of bit 14 while siod_out is low
        load_rom(0);
        build_model();
        @(negedge clk);
        drive(0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0);
        k0 = 2 + 2 * Q + 13 * 4 * Q;
        mc = k0 + Q + 1;
        repeat (mc) @(negedge clk);
        check("pre_rst_state", observe(0), exp_q[mc]);
        #2 rst = 1'b1;
        #1 check("rst_async", observe(0), {3'b111, 2'b00, 8'h00});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat ($urandom_range(3, 10)) @(negedge clk);
        check("idle_after_rst", observe(0), {3'b111, 2'b00, 8'h00});
        run_seq(0, 1'b1, 1, fd);
        o = observe(0);
        check("replay_done", o.done, 1);
        check("replay_idx", o.idx, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
